engine_read_arbiter: RTL and testbench

ENGINE_READ_ARBITER -- requirements
Module: engine_read_arbiter

---
 rtl/engine_read_arbiter.sv | 178 +++++++++++++++++
 tb/tb_engine_read_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_read_arbiter.sv
// Round-robin read-address arbiter for four engine clients
// with a one-entry R buffer that routes beats back by ID.
module engine_read_arbiter #(
  parameter int NUM_ENGINES         = 4,
  parameter int C0_C_S_AXI_ID_WIDTH = 12,
  parameter int MAX_OUTSTANDING     = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_ENGINES*(C0_C_S_AXI_ID_WIDTH-2)-1:0] eng_rd_id_in,
  input  logic [NUM_ENGINES*33-1:0]                     eng_rd_addr_in,
  input  logic [NUM_ENGINES*8-1:0]                      eng_rd_len_in,
  input  logic [NUM_ENGINES-1:0]                        eng_rd_info_valid_in,
  output logic [NUM_ENGINES-1:0]                        eng_rd_info_rdy_out,
  output logic [255:0]                                  eng_rd_data_out,
  output logic [NUM_ENGINES-1:0]                        eng_rd_data_valid_out,
  input  logic [NUM_ENGINES-1:0]                        eng_rd_data_rdy_in,
  output logic [C0_C_S_AXI_ID_WIDTH-1:0]                ar_id_out,
  output logic [32:0]                                   ar_addr_out,
  output logic [7:0]                                    ar_len_out,
  output logic                                          ar_valid_out,
  input  logic                                          ar_ready_in,
  input  logic [C0_C_S_AXI_ID_WIDTH-1:0]                r_id_in,
  input  logic [255:0]                                  r_data_in,
  input  logic                                          r_last_in,
  input  logic                                          r_valid_in,
  output logic                                          r_ready_out
);
  localparam int IW  = C0_C_S_AXI_ID_WIDTH;
  localparam int EIW = C0_C_S_AXI_ID_WIDTH - 2;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e         state_q, state_d;
  logic [1:0]     last_q, last_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [EIW-1:0] id_q, id_d;
  logic [32:0]    addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [2:0]     cnt_q [NUM_ENGINES];
  logic [2:0]     cnt_d [NUM_ENGINES];
  logic           buf_valid_q, buf_valid_d;
  logic [1:0]     buf_eng_q, buf_eng_d;
  logic [255:0]   buf_data_q, buf_data_d;
  logic           buf_last_q, buf_last_d;

  logic [NUM_ENGINES-1:0] elig, inc, dec;
  logic [1:0] sel, cand, r_eng;
  logic       found, grant, r_hs, pop;
  logic       unused_bits;

  assign r_eng = r_id_in[IW-1 -: 2];
  assign unused_bits = ^{r_id_in[EIW-1:0], buf_last_q};

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      elig[i] = eng_rd_info_valid_in[i]
             && (cnt_q[i] < 3'(MAX_OUTSTANDING));
  end

  // search starts one past the last winner
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_ENGINES; k++) begin
      cand = last_q + 2'(k);
      if (!found && elig[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign grant = rst && (state_q == IDLE) && found;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    eng_rd_info_rdy_out = '0;
    ar_valid_out        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          eng_rd_info_rdy_out[sel] = 1'b1;
          gnt_d   = sel;
          last_d  = sel;
          id_d    = eng_rd_id_in[sel*EIW +: EIW];
          addr_d  = eng_rd_addr_in[sel*33 +: 33];
          len_d   = eng_rd_len_in[sel*8 +: 8];
          state_d = HOLD;
        end
      end
      HOLD: begin
        ar_valid_out = 1'b1;
        if (ar_ready_in) state_d = IDLE;
      end
    endcase
  end

  assign ar_id_out   = {gnt_q, id_q};
  assign ar_addr_out = addr_q;
  assign ar_len_out  = len_q;

  assign r_ready_out = !buf_valid_q || eng_rd_data_rdy_in[buf_eng_q];
  assign r_hs = r_valid_in && r_ready_out;
  assign pop  = buf_valid_q && eng_rd_data_rdy_in[buf_eng_q];

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      inc[i]   = grant && (sel == 2'(i));
      dec[i]   = r_hs && r_last_in && (r_eng == 2'(i));
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i])
        cnt_d[i] = cnt_q[i] + 3'd1;
      else if (dec[i] && !inc[i] && cnt_q[i] != 3'd0)
        cnt_d[i] = cnt_q[i] - 3'd1;
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_eng_d   = buf_eng_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    if (pop) buf_valid_d = 1'b0;
    if (r_hs) begin
      buf_valid_d = 1'b1;
      buf_eng_d   = r_eng;
      buf_data_d  = r_data_in;
      buf_last_d  = r_last_in;
    end
  end

  always_comb begin
    eng_rd_data_valid_out = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      eng_rd_data_valid_out[i] = buf_valid_q && (buf_eng_q == 2'(i));
  end

  assign eng_rd_data_out = buf_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 2'(NUM_ENGINES - 1);
      gnt_q       <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_eng_q   <= '0;
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      buf_valid_q <= buf_valid_d;
      buf_eng_q   <= buf_eng_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      for (int i = 0; i < NUM_ENGINES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_engine_read_arbiter.sv
// Bench for engine_read_arbiter: grant table, AR and R
// scoreboards, back-pressure and reset corner cases.
module tb_engine_read_arbiter;
  localparam int EIW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4*EIW-1:0] id_in;
  logic [4*33-1:0]  addr_in;
  logic [4*8-1:0]   len_in;
  logic [3:0]   info_valid, info_rdy, data_valid, data_rdy;
  logic [255:0] data_out, r_data;
  logic [11:0]  ar_id, r_id;
  logic [32:0]  ar_addr;
  logic [7:0]   ar_len;
  logic ar_valid, ar_ready, r_last, r_valid, r_ready;

  logic [EIW-1:0] eng_id   [4];
  logic [32:0]    eng_addr [4];
  logic [7:0]     eng_len  [4];

  typedef struct {logic [11:0] id; logic [32:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [1:0] eng; logic [255:0] data;} rd_t;
  typedef struct {logic [3:0] rdy; logic arv;} vec_t;

  ar_t  arq[$];
  rd_t  rdq[$];
  vec_t v21[8];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    id_in = '0; addr_in = '0; len_in = '0;
    for (int i = 0; i < 4; i++) begin
      id_in[i*EIW +: EIW] = eng_id[i];
      addr_in[i*33 +: 33] = eng_addr[i];
      len_in[i*8 +: 8]    = eng_len[i];
    end
  end

  engine_read_arbiter dut (
    .clk(clk), .rst(rst),
    .eng_rd_id_in(id_in), .eng_rd_addr_in(addr_in),
    .eng_rd_len_in(len_in), .eng_rd_info_valid_in(info_valid),
    .eng_rd_info_rdy_out(info_rdy), .eng_rd_data_out(data_out),
    .eng_rd_data_valid_out(data_valid), .eng_rd_data_rdy_in(data_rdy),
    .ar_id_out(ar_id), .ar_addr_out(ar_addr), .ar_len_out(ar_len),
    .ar_valid_out(ar_valid), .ar_ready_in(ar_ready),
    .r_id_in(r_id), .r_data_in(r_data), .r_last_in(r_last),
    .r_valid_in(r_valid), .r_ready_out(r_ready)
  );

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    info_valid = '0; data_rdy = '0; ar_ready = 1'b0;
    r_id = '0; r_data = '0; r_last = 1'b0; r_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    arq.delete();
    rdq.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_rdy"}, info_rdy, 4'b0);
    chk({tag, "_arv"}, ar_valid, 1'b0);
    chk({tag, "_dv"}, data_valid, 4'b0);
    chk({tag, "_arid"}, ar_id, 12'h0);
    chk({tag, "_araddr"}, ar_addr, 33'h0);
    chk({tag, "_arlen"}, ar_len, 8'h0);
    chk({tag, "_data"}, data_out, 256'h0);
    chk({tag, "_rready"}, r_ready, 1'b1);
  endtask

  function automatic logic [1:0] oh2i(logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic ar_push(logic [1:0] e);
    arq.push_back('{id: {e, eng_id[e]}, addr: eng_addr[e], len: eng_len[e]});
  endtask

  task automatic ar_pop_check();
    ar_t x;
    if (arq.size() == 0) begin
      chk("ar_q_empty", 1'b1, 1'b0);
    end else begin
      x = arq.pop_front();
      chk("ar_id", ar_id, x.id);
      chk("ar_addr", ar_addr, x.addr);
      chk("ar_len", ar_len, x.len);
    end
  endtask

  task automatic rd_check();
    logic [3:0] ev;
    logic er;
    ev = 4'b0;
    er = 1'b1;
    if (rdq.size() != 0) begin
      ev = 4'b1 << rdq[0].eng;
      er = data_rdy[rdq[0].eng];
    end
    chk("rd_valid", data_valid, ev);
    chk("r_ready", r_ready, er);
    if (rdq.size() != 0) begin
      chk("rd_data", data_out, rdq[0].data);
      if (data_rdy[rdq[0].eng]) void'(rdq.pop_front());
    end
    if (r_valid && er) rdq.push_back('{eng: r_id[11:10], data: r_data});
  endtask

  initial begin
    v21[0] = '{4'b0001, 1'b0};
    v21[1] = '{4'b0000, 1'b1};
    v21[2] = '{4'b0100, 1'b0};
    v21[3] = '{4'b0000, 1'b1};
    v21[4] = '{4'b0001, 1'b0};
    v21[5] = '{4'b0000, 1'b1};
    v21[6] = '{4'b0100, 1'b0};
    v21[7] = '{4'b0000, 1'b1};
    for (int i = 0; i < 4; i++) begin
      eng_id[i]   = 10'(12'h0A0 + i);
      eng_addr[i] = 33'h0_1000_0000 + 33'(i * 256);
      eng_len[i]  = 8'(i + 1);
    end

    // reset state with requests already pending
    clear_inputs();
    info_valid = 4'b0101;
    ar_ready = 1'b1;
    tick();
    tick();
    #1;
    chk_reset_outs("rst0");

    // round-robin between engines 0 and 2
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_rdy", info_rdy, v21[i].rdy);
      chk("rr_arv", ar_valid, v21[i].arv);
      if (v21[i].rdy != 4'b0) ar_push(oh2i(v21[i].rdy));
      if (v21[i].arv && ar_ready) ar_pop_check();
      tick();
    end
    info_valid = '0;

    // held AR with stable fields
    do_reset();
    eng_id[1] = 10'h155;
    eng_addr[1] = 33'h1_0000_0040;
    eng_len[1] = 8'd4;
    info_valid = 4'b0010;
    #1;
    chk("h_rdy", info_rdy, 4'b0010);
    chk("h_arv0", ar_valid, 1'b0);
    ar_push(2'd1);
    tick();
    info_valid = '0;
    eng_id[1] = 10'h2AA;
    eng_addr[1] = 33'h0_DEAD_BEEF;
    eng_len[1] = 8'd9;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("h_arv", ar_valid, 1'b1);
      chk("h_id", ar_id, 12'h555);
      chk("h_addr", ar_addr, 33'h1_0000_0040);
      chk("h_len", ar_len, 8'd4);
      chk("h_rdy_lo", info_rdy, 4'b0);
      tick();
    end
    ar_ready = 1'b1;
    #1;
    chk("h_arv_hs", ar_valid, 1'b1);
    ar_pop_check();
    tick();
    ar_ready = 1'b0;
    #1;
    chk("h_idle_arv", ar_valid, 1'b0);
    chk("h_idle_rdy", info_rdy, 4'b0);

    // outstanding limit on engine 3
    do_reset();
    info_valid = 4'b1000;
    ar_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lim_rdy", info_rdy, (i % 2 == 0) ? 4'b1000 : 4'b0000);
      chk("lim_arv", ar_valid, (i % 2 == 1));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lim_block_rdy", info_rdy, 4'b0);
      chk("lim_block_arv", ar_valid, 1'b0);
      tick();
    end
    data_rdy = 4'b1111;
    r_valid = 1'b1;
    r_id = {2'b11, 10'h0};
    r_last = 1'b1;
    r_data = 256'hC0FFEE;
    #1;
    chk("lim_rready", r_ready, 1'b1);
    chk("lim_still_blk", info_rdy, 4'b0);
    tick();
    r_valid = 1'b0;
    r_last = 1'b0;
    #1;
    chk("lim_regrant", info_rdy, 4'b1000);
    chk("lim_dv", data_valid, 4'b1000);
    tick();
    #1;
    chk("lim_arv5", ar_valid, 1'b1);

    // back-to-back beats for engine 1
    do_reset();
    data_rdy = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        r_valid = 1'b1;
        r_id = {2'b01, 10'(i)};
        r_data = {8{32'h1111_0000 + 32'(i)}};
      end else begin
        r_valid = 1'b0;
      end
      #1;
      rd_check();
      tick();
    end

    // stalled engine 0 holds the buffer, engine 2 still granted
    do_reset();
    data_rdy = 4'b1110;
    r_valid = 1'b1;
    r_id = {2'b00, 10'h3};
    r_data = {4{64'hAAAA_0000_0000_0001}};
    #1;
    rd_check();
    tick();
    r_data = {4{64'hBBBB_0000_0000_0002}};
    info_valid = 4'b0100;
    #1;
    rd_check();
    chk("stall_grant2", info_rdy, 4'b0100);
    tick();
    info_valid = '0;
    #1;
    rd_check();
    tick();
    data_rdy = 4'b1111;
    #1;
    rd_check();
    tick();
    r_valid = 1'b0;
    #1;
    rd_check();
    tick();
    #1;
    rd_check();

    // reset during HOLD with a buffered beat
    do_reset();
    info_valid = 4'b0001;
    #1;
    chk("mr_rdy", info_rdy, 4'b0001);
    tick();
    info_valid = '0;
    r_valid = 1'b1;
    r_id = {2'b10, 10'h1};
    r_data = 256'h1234;
    #1;
    chk("mr_arv", ar_valid, 1'b1);
    tick();
    r_valid = 1'b0;
    #1;
    chk("mr_dv", data_valid, 4'b0100);
    rst = 1'b0;
    #1;
    chk_reset_outs("mr");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_arv", ar_valid, 1'b0);
      chk("post_rdy", info_rdy, 4'b0);
      chk("post_dv", data_valid, 4'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
